// File: rtl/sc_et_scheduler.sv
// Job-level controller for one stochastic-computing lane with variable early termination.
// Accepts a job, drives the ET unit and SNGs, counts stream bits and returns the result.
module sc_et_scheduler #(
    parameter int CTR_WIDTH = 8,
    parameter int LEN_WIDTH = 10,
    parameter int LAT       = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 job_valid,
    output logic                 job_ready,
    input  logic [CTR_WIDTH-1:0] job_nmin,
    input  logic [LEN_WIDTH-1:0] job_nmax,
    output logic [CTR_WIDTH-1:0] et_nmin,
    output logic                 et_clr,
    input  logic                 et_done,
    output logic                 sng_clr,
    output logic                 sng_en,
    input  logic                 bit_in,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [LEN_WIDTH-1:0] res_ones,
    output logic [LEN_WIDTH-1:0] res_len,
    output logic                 res_early
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t               state, state_nx;
    logic [LEN_WIDTH-1:0] cap;
    logic [LEN_WIDTH-1:0] issued;
    logic [LEN_WIDTH-1:0] ones;
    logic                 early, early_nx;
    logic [LAT-1:0]       vpipe;
    logic [LAT:0]         vshift;
    logic                 accept;
    logic                 at_cap;
    logic                 bit_valid;

    // job_ready is only ever high in IDLE, so it alone qualifies an accept
    assign accept    = job_valid & job_ready;
    assign at_cap    = (issued == cap);
    assign vshift    = {vpipe, sng_en};
    assign bit_valid = vpipe[LAT-1];

    assign res_len   = issued;
    assign res_ones  = ones;
    assign res_early = early;

    always_comb begin
        state_nx  = state;
        early_nx  = early;
        et_clr    = 1'b0;
        sng_clr   = 1'b0;
        sng_en    = 1'b0;
        res_valid = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept) state_nx = S_LOAD;
            end
            S_LOAD: begin
                et_clr   = 1'b1;
                sng_clr  = 1'b1;
                state_nx = S_RUN;
            end
            S_RUN: begin
                sng_en = ~et_done & ~at_cap;
                // cap is checked first so it wins over a simultaneous et_done
                if (at_cap) begin
                    early_nx = 1'b0;
                    state_nx = S_FLUSH;
                end else if (et_done) begin
                    early_nx = 1'b1;
                    state_nx = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (vpipe == '0) state_nx = S_DONE;
            end
            S_DONE: begin
                res_valid = 1'b1;
                if (res_ready) state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            job_ready <= 1'b0;
            et_nmin   <= '0;
            cap       <= '0;
            issued    <= '0;
            ones      <= '0;
            early     <= 1'b0;
            vpipe     <= '0;
        end else begin
            state     <= state_nx;
            job_ready <= (state_nx == S_IDLE);
            early     <= early_nx;
            vpipe     <= vshift[LAT-1:0];
            if (accept) begin
                et_nmin <= job_nmin;
                cap     <= job_nmax;
                issued  <= '0;
                ones    <= '0;
                early   <= 1'b0;
            end else begin
                if (sng_en)             issued <= issued + LEN_WIDTH'(1);
                if (bit_valid & bit_in) ones   <= ones + LEN_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_sc_et_scheduler.sv
// Directed, table-driven bench for sc_et_scheduler with hand-computed expectations.
// Inputs change at the falling edge; outputs are sampled 1 time unit later.
module tb_sc_et_scheduler;

    localparam int CW  = 8;
    localparam int LW  = 10;
    localparam int LAT = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          job_valid = 1'b0;
    logic          job_ready;
    logic [CW-1:0] job_nmin = '0;
    logic [LW-1:0] job_nmax = '0;
    logic [CW-1:0] et_nmin;
    logic          et_clr;
    logic          et_done = 1'b0;
    logic          sng_clr;
    logic          sng_en;
    logic          bit_in = 1'b0;
    logic          res_valid;
    logic          res_ready = 1'b0;
    logic [LW-1:0] res_ones;
    logic [LW-1:0] res_len;
    logic          res_early;

    int n_chk  = 0;
    int n_fail = 0;

    sc_et_scheduler #(.CTR_WIDTH(CW), .LEN_WIDTH(LW), .LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .job_valid(job_valid), .job_ready(job_ready),
        .job_nmin(job_nmin), .job_nmax(job_nmax),
        .et_nmin(et_nmin), .et_clr(et_clr), .et_done(et_done),
        .sng_clr(sng_clr), .sng_en(sng_en), .bit_in(bit_in),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_ones(res_ones), .res_len(res_len), .res_early(res_early)
    );

    always #5 clk = ~clk;

    // mode: 0 = bits all 1, 1 = alternating 1,0,..., 2 = all 0 (1 driven outside the bit window)
    // et_at: RUN cycle (1-based) from which et_done is held high, 0 = never
    // vrc: RUN-relative cycle in which res_valid is first seen
    typedef struct {
        int nmin;
        int nmax;
        int et_at;
        int mode;
        int len;
        int ones;
        int early;
        int vrc;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic start_job(input int nmin, input int nmax);
        @(negedge clk);
        job_valid = 1'b1;
        job_nmin  = CW'(nmin);
        job_nmax  = LW'(nmax);
        #1 chk("accept_job_ready", int'(job_ready), 1);
        @(negedge clk);
        job_valid = 1'b0;
        et_done   = 1'b0;
        #1;
        chk("load_et_clr", int'(et_clr), 1);
        chk("load_sng_clr", int'(sng_clr), 1);
        chk("load_sng_en", int'(sng_en), 0);
        chk("load_job_ready", int'(job_ready), 0);
    endtask

    task automatic run_to_done(input vec_t v);
        int rc, ns, nclr, k;
        bit got;
        rc = 0; ns = 0; nclr = 0; got = 1'b0;
        while (!got && rc < 1100) begin
            @(negedge clk);
            rc++;
            et_done = (v.et_at != 0) && (rc >= v.et_at);
            k = rc - LAT;
            if (k < 1 || k > v.len) bit_in = 1'b1;
            else if (v.mode == 0)   bit_in = 1'b1;
            else if (v.mode == 1)   bit_in = (k % 2) == 1;
            else                    bit_in = 1'b0;
            #1;
            if (sng_en) ns++;
            if (et_clr || sng_clr) nclr++;
            if (res_valid) got = 1'b1;
        end
        chk("res_valid_cycle", got ? rc : -1, v.vrc);
        chk("sng_en_count", ns, v.len);
        chk("extra_clr_pulses", nclr, 0);
        chk("res_len", int'(res_len), v.len);
        chk("res_ones", int'(res_ones), v.ones);
        chk("res_early", int'(res_early), v.early);
        chk("et_nmin", int'(et_nmin), v.nmin);
    endtask

    task automatic release_result();
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        #1;
        chk("release_res_valid", int'(res_valid), 0);
        chk("release_job_ready", int'(job_ready), 1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_job_ready"}, int'(job_ready), 0);
        chk({tag, "_et_clr"}, int'(et_clr), 0);
        chk({tag, "_sng_clr"}, int'(sng_clr), 0);
        chk({tag, "_sng_en"}, int'(sng_en), 0);
        chk({tag, "_res_valid"}, int'(res_valid), 0);
        chk({tag, "_res_early"}, int'(res_early), 0);
        chk({tag, "_et_nmin"}, int'(et_nmin), 0);
        chk({tag, "_res_ones"}, int'(res_ones), 0);
        chk({tag, "_res_len"}, int'(res_len), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{nmin: 4,   nmax: 100,  et_at: 6, mode: 0, len: 5,    ones: 5,   early: 1, vrc: 9};
        vecs[1] = '{nmin: 1,   nmax: 8,    et_at: 0, mode: 1, len: 8,    ones: 4,   early: 0, vrc: 12};
        vecs[2] = '{nmin: 2,   nmax: 3,    et_at: 4, mode: 0, len: 3,    ones: 3,   early: 0, vrc: 7};
        vecs[3] = '{nmin: 3,   nmax: 0,    et_at: 0, mode: 0, len: 0,    ones: 0,   early: 0, vrc: 3};
        vecs[4] = '{nmin: 9,   nmax: 10,   et_at: 4, mode: 1, len: 3,    ones: 2,   early: 1, vrc: 7};
        vecs[5] = '{nmin: 7,   nmax: 5,    et_at: 1, mode: 0, len: 0,    ones: 0,   early: 1, vrc: 3};
        vecs[6] = '{nmin: 255, nmax: 5,    et_at: 0, mode: 2, len: 5,    ones: 0,   early: 0, vrc: 9};
        vecs[7] = '{nmin: 0,   nmax: 1023, et_at: 0, mode: 1, len: 1023, ones: 512, early: 0, vrc: 1027};

        // reset state
        #1 chk_all_zero("reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1 chk("post_reset_job_ready_first", int'(job_ready), 0);
        @(negedge clk);
        #1 chk("post_reset_job_ready_rise", int'(job_ready), 1);

        for (int unsigned i = 0; i < 8; i++) begin
            start_job(vecs[i].nmin, vecs[i].nmax);
            run_to_done(vecs[i]);
            release_result();
        end

        // backpressure in DONE while a new job is already offered
        start_job(5, 2);
        run_to_done('{nmin: 5, nmax: 2, et_at: 0, mode: 0, len: 2, ones: 2, early: 0, vrc: 6});
        job_valid = 1'b1;
        job_nmin  = CW'(77);
        job_nmax  = LW'(1);
        for (int unsigned h = 0; h < 5; h++) begin
            @(negedge clk);
            #1;
            chk("bp_res_valid", int'(res_valid), 1);
            chk("bp_res_len", int'(res_len), 2);
            chk("bp_res_ones", int'(res_ones), 2);
            chk("bp_res_early", int'(res_early), 0);
            chk("bp_job_ready", int'(job_ready), 0);
            chk("bp_et_nmin", int'(et_nmin), 5);
        end
        release_result();
        @(negedge clk);
        job_valid = 1'b0;
        et_done   = 1'b0;
        #1;
        chk("bp_next_load_et_clr", int'(et_clr), 1);
        chk("bp_next_et_nmin", int'(et_nmin), 77);
        run_to_done('{nmin: 77, nmax: 1, et_at: 0, mode: 0, len: 1, ones: 1, early: 0, vrc: 5});
        release_result();

        // reset in the middle of RUN, then a clean job
        start_job(3, 50);
        for (int unsigned c = 0; c < 6; c++) begin
            @(negedge clk);
            et_done = 1'b0;
            bit_in  = 1'b1;
        end
        @(negedge clk);
        rst = 1'b1;
        #1 chk_all_zero("midrun_reset");
        @(negedge clk);
        rst = 1'b0;
        #1 chk("midrun_job_ready_first", int'(job_ready), 0);
        @(negedge clk);
        #1 chk("midrun_job_ready_rise", int'(job_ready), 1);
        start_job(6, 4);
        run_to_done('{nmin: 6, nmax: 4, et_at: 0, mode: 0, len: 4, ones: 4, early: 0, vrc: 8});
        release_result();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
